// File: rtl/channel_scheduler.sv
// Three-channel transmit-path scheduler: grants one requester for a fixed burst, then a fixed idle gap.
// Build option: define CHANNEL_SCHEDULER_FIXED_PRIO_EN for fixed priority ch3 > ch2 > ch1 instead of round-robin.
module channel_scheduler #(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       ena,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic [3:0] bin,
  output logic       busy,
  output logic       sof,
  output logic       eof
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BURST_INIT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_INIT   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
  localparam bit HAS_GAP = (GAP_LEN != 0);
  localparam logic [3:0] BIN_IDLE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [2:0]       r_grant;
  logic [3:0]       r_bin;
  logic             r_busy;
  logic             r_sof;
  logic             r_eof;

  logic [2:0]       w_winner;
  logic [3:0]       w_winner_bin;
  logic             w_burst_end;

`ifdef CHANNEL_SCHEDULER_FIXED_PRIO_EN
  // Fixed priority, matching the downstream channel encoder.
  always_comb begin
    w_winner = 3'b000;
    if (req[2])      w_winner = 3'b100;
    else if (req[1]) w_winner = 3'b010;
    else if (req[0]) w_winner = 3'b001;
  end
`else
  logic [2:0] r_rr_last;

  // Round-robin: search starts at the channel after the last one served.
  always_comb begin
    w_winner = 3'b000;
    case (r_rr_last)
      3'b001: begin
        if (req[1])      w_winner = 3'b010;
        else if (req[2]) w_winner = 3'b100;
        else if (req[0]) w_winner = 3'b001;
      end
      3'b010: begin
        if (req[2])      w_winner = 3'b100;
        else if (req[0]) w_winner = 3'b001;
        else if (req[1]) w_winner = 3'b010;
      end
      default: begin
        if (req[0])      w_winner = 3'b001;
        else if (req[1]) w_winner = 3'b010;
        else if (req[2]) w_winner = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_rr_last <= 3'b100;
    end else if (ena && (r_state == ST_IDLE) && (req != 3'b000)) begin
      r_rr_last <= w_winner;
    end
  end
`endif

  always_comb begin
    case (w_winner)
      3'b001:  w_winner_bin = 4'h1;
      3'b010:  w_winner_bin = 4'h2;
      3'b100:  w_winner_bin = 4'h3;
      default: w_winner_bin = BIN_IDLE;
    endcase
  end

  // Abort (granted channel dropped its request) and normal end share one exit path.
  assign w_burst_end = ((req & r_grant) == 3'b000) || (r_burst_cnt == '0);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
      r_grant     <= 3'b000;
      r_bin       <= BIN_IDLE;
      r_busy      <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
    end else begin
      r_sof <= 1'b0;
      r_eof <= 1'b0;
      if (ena) begin
        case (r_state)
          ST_IDLE: begin
            if (req != 3'b000) begin
              r_state     <= ST_BURST;
              r_grant     <= w_winner;
              r_bin       <= w_winner_bin;
              r_busy      <= 1'b1;
              r_sof       <= 1'b1;
              r_burst_cnt <= BURST_INIT;
            end
          end
          ST_BURST: begin
            if (w_burst_end) begin
              r_grant <= 3'b000;
              r_bin   <= BIN_IDLE;
              r_busy  <= 1'b0;
              r_eof   <= 1'b1;
              if (HAS_GAP) begin
                r_state   <= ST_GAP;
                r_gap_cnt <= GAP_INIT;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_burst_cnt <= r_burst_cnt - 1'b1;
            end
          end
          ST_GAP: begin
            if (r_gap_cnt == '0) r_state <= ST_IDLE;
            else                 r_gap_cnt <= r_gap_cnt - 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign grant = r_grant;
  assign bin   = r_bin;
  assign busy  = r_busy;
  assign sof   = r_sof;
  assign eof   = r_eof;

endmodule

// File: tb/tb_channel_scheduler.sv
// Directed bench for channel_scheduler (BURST_LEN=4, GAP_LEN=2) with hand-computed expectations.
module tb_channel_scheduler;

  logic       clk;
  logic       arst;
  logic       ena;
  logic [2:0] req;
  logic [2:0] grant;
  logic [3:0] bin;
  logic       busy;
  logic       sof;
  logic       eof;

  int n_checks = 0;
  int n_errors = 0;

  channel_scheduler #(.BURST_LEN(4), .GAP_LEN(2)) dut (
    .clk   (clk),
    .arst  (arst),
    .ena   (ena),
    .req   (req),
    .grant (grant),
    .bin   (bin),
    .busy  (busy),
    .sof   (sof),
    .eof   (eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_bin(input logic [2:0] g);
    case (g)
      3'b001:  return 4'h1;
      3'b010:  return 4'h2;
      3'b100:  return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  task automatic chk_out(input string tag, input logic [2:0] g, input logic s, input logic e);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".bin"},   32'(bin),   32'(exp_bin(g)));
    chk({tag, ".busy"},  32'(busy),  32'(g != 3'b000));
    chk({tag, ".sof"},   32'(sof),   32'(s));
    chk({tag, ".eof"},   32'(eof),   32'(e));
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_exp [4];
  logic [2:0] g;
  logic [3:0] ena_pat;

  initial begin
    arst = 1'b0;
    ena  = 1'b0;
    req  = 3'b000;
`ifdef CHANNEL_SCHEDULER_FIXED_PRIO_EN
    rr_exp = '{3'b100, 3'b100, 3'b100, 3'b100};
`else
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif

    repeat (3) step();
    chk_out("reset", 3'b000, 1'b0, 1'b0);
    arst = 1'b1;
    ena  = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("idle", 3'b000, 1'b0, 1'b0);
    end

    // All three request: round-robin starts at ch1 after reset.
    req = 3'b111;
    for (int b = 0; b < 4; b++) begin
      for (int k = 1; k <= 7; k++) begin
        step();
        g = (k <= 4) ? rr_exp[b] : 3'b000;
        chk_out($sformatf("rr%0d_k%0d", b, k), g, k == 1, k == 5);
      end
    end
    req = 3'b000;
    repeat (3) step();

    // Lone requester ch2, two back-to-back bursts with gap and arbitration.
    req = 3'b010;
    for (int b = 0; b < 2; b++) begin
      for (int k = 1; k <= 7; k++) begin
        step();
        g = (k <= 4) ? 3'b010 : 3'b000;
        chk_out($sformatf("solo%0d_k%0d", b, k), g, k == 1, k == 5);
      end
    end
    req = 3'b000;
    repeat (3) step();
    chk_out("solo_settle", 3'b000, 1'b0, 1'b0);

    // Abort: ch1 drops its request on the 2nd burst cycle; requests ignored during gap.
    req = 3'b001;
    step();
    chk_out("abort_k1", 3'b001, 1'b1, 1'b0);
    step();
    chk_out("abort_k2", 3'b001, 1'b0, 1'b0);
    req = 3'b000;
    step();
    chk_out("abort_k3", 3'b000, 1'b0, 1'b1);
    req = 3'b001;
    step();
    chk_out("abort_gap0", 3'b000, 1'b0, 1'b0);
    step();
    chk_out("abort_gap1", 3'b000, 1'b0, 1'b0);
    step();
    chk_out("abort_regrant", 3'b001, 1'b1, 1'b0);
    req = 3'b000;
    step();
    chk_out("abort_drop2", 3'b000, 1'b0, 1'b1);
    repeat (3) step();

    // ena toggling: burst of 4 enabled cycles spans 8 clocks.
    req = 3'b100;
    step();
    chk_out("ena_k1", 3'b100, 1'b1, 1'b0);
    for (int k = 2; k <= 10; k++) begin
      ena = (k % 2 == 1);
      step();
      g = (k <= 8) ? 3'b100 : 3'b000;
      chk_out($sformatf("ena_k%0d", k), g, 1'b0, k == 9);
    end
    ena = 1'b1;
    req = 3'b000;
    repeat (4) step();

    // Asynchronous reset mid-burst, then fresh grant to ch3.
    req = 3'b100;
    step();
    chk_out("rst_k1", 3'b100, 1'b1, 1'b0);
    step();
    #2;
    arst = 1'b0;
    #1;
    chk_out("rst_async", 3'b000, 1'b0, 1'b0);
    step();
    chk_out("rst_hold", 3'b000, 1'b0, 1'b0);
    arst = 1'b1;
    step();
    chk_out("rst_regrant", 3'b100, 1'b1, 1'b0);
    step();
    chk_out("rst_k2", 3'b100, 1'b0, 1'b0);

    // ena low keeps grant but pulses never stretch.
    ena_pat = 4'b0000;
    ena = ena_pat[0];
    repeat (3) begin
      step();
      chk_out("ena_hold", 3'b100, 1'b0, 1'b0);
    end
    ena = 1'b1;
    req = 3'b000;
    step();
    chk_out("ena_hold_abort", 3'b000, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
